// File: rtl/floor_scroller.sv
// Floor scroller: owns the 8 platforms and scrolls them down while the slime is pinned at the ceiling.
// Optional thinning of recycled floors is enabled by defining FLOOR_THIN_EN.
module floor_scroller #(
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int          FLOOR_W   = 40,
    parameter int          SPACING   = 60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clk_vga,
    input  logic       hit_ceiling,
    input  logic [8:0] time_gap,
    input  logic       slime_die,
    output logic [9:0] floor_pos_x0,
    output logic [9:0] floor_pos_x1,
    output logic [9:0] floor_pos_x2,
    output logic [9:0] floor_pos_x3,
    output logic [9:0] floor_pos_x4,
    output logic [9:0] floor_pos_x5,
    output logic [9:0] floor_pos_x6,
    output logic [9:0] floor_pos_x7,
    output logic [9:0] floor_pos_y0,
    output logic [9:0] floor_pos_y1,
    output logic [9:0] floor_pos_y2,
    output logic [9:0] floor_pos_y3,
    output logic [9:0] floor_pos_y4,
    output logic [9:0] floor_pos_y5,
    output logic [9:0] floor_pos_y6,
    output logic [9:0] floor_pos_y7,
    output logic [7:0] enable,
    output logic       scroll,
    output logic [7:0] recycle_cnt
);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_DEAD = 1'b1
    } state_t;

    // x range so that x + FLOOR_W stays within the 619-px playfield edge
    localparam logic [9:0] X_SPAN = 10'(620 - FLOOR_W);
    localparam logic [9:0] Y_LAST = 10'd479;

    function automatic logic [9:0] reset_x(input int idx);
        logic [9:0] v;
        case (idx)
            0:       v = 10'd290;
            1:       v = 10'd100;
            2:       v = 10'd450;
            3:       v = 10'd200;
            4:       v = 10'd500;
            5:       v = 10'd50;
            6:       v = 10'd350;
            7:       v = 10'd250;
            default: v = 10'd0;
        endcase
        return v;
    endfunction

    function automatic logic [9:0] reset_y(input int idx);
        return 10'd460 - 10'(SPACING * idx);
    endfunction

    function automatic logic lfsr_fb(input logic [15:0] v);
        return v[0] ^ v[2] ^ v[3] ^ v[5];
    endfunction

    // Rise profile of the slime: full rate, then 1/2, 1/4, 1/8 per tick
    function automatic logic phase_ok(input logic [8:0] tg);
        logic ok;
        if (tg >= 9'd1 && tg <= 9'd79) begin
            ok = 1'b1;
        end else if (tg >= 9'd80 && tg <= 9'd159) begin
            ok = (tg[0] == 1'b0);
        end else if (tg >= 9'd160 && tg <= 9'd239) begin
            ok = (tg[1:0] == 2'b00);
        end else if (tg >= 9'd240 && tg <= 9'd319) begin
            ok = (tg[2:0] == 3'b000);
        end else begin
            ok = 1'b0;
        end
        return ok;
    endfunction

    state_t      state_r;
    state_t      state_nxt_s;
    logic [15:0] lfsr_r;
    logic [9:0]  y_r [8];
    logic [9:0]  x_r [8];
    logic [7:0]  enable_r;
    logic        scroll_r;
    logic [7:0]  recycle_cnt_r;

    logic        step_s;
    logic [9:0]  rand_x_s;
    logic [7:0]  wrap_s;
    logic        any_wrap_s;
    logic [7:0]  cnt_nxt_s;

    // FSM next state: death is sticky until reset
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (slime_die) begin
                    state_nxt_s = ST_DEAD;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DEAD: state_nxt_s = ST_DEAD;
            default: state_nxt_s = ST_DEAD;
        endcase
    end

    // Step qualification; a same-cycle death suppresses movement
    always_comb begin
        step_s = (state_r == ST_RUN) && !slime_die && clk_vga && hit_ceiling && phase_ok(time_gap);
    end

    // Fold the 10-bit LFSR slice into 0..X_SPAN-1
    always_comb begin
        if (lfsr_r[9:0] < X_SPAN) begin
            rand_x_s = lfsr_r[9:0];
        end else begin
            rand_x_s = lfsr_r[9:0] - X_SPAN;
        end
    end

    // Floors at the bottom row wrap to the top on the next step
    always_comb begin
        wrap_s = 8'h00;
        for (int i = 0; i < 8; i++) begin
            wrap_s[i] = (y_r[i] == Y_LAST);
        end
        any_wrap_s = |wrap_s;
        if (recycle_cnt_r == 8'd255) begin
            cnt_nxt_s = 8'd255;
        end else begin
            cnt_nxt_s = recycle_cnt_r + 8'd1;
        end
    end

    // Main state: FSM, LFSR, positions, scroll pulse and recycle counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_RUN;
            lfsr_r        <= LFSR_SEED;
            scroll_r      <= 1'b0;
            recycle_cnt_r <= 8'd0;
            for (int i = 0; i < 8; i++) begin
                y_r[i] <= reset_y(i);
                x_r[i] <= reset_x(i);
            end
        end else begin
            state_r  <= state_nxt_s;
            lfsr_r   <= {lfsr_fb(lfsr_r), lfsr_r[15:1]};
            scroll_r <= step_s;
            if (step_s) begin
                for (int i = 0; i < 8; i++) begin
                    if (wrap_s[i]) begin
                        y_r[i] <= 10'd0;
                        x_r[i] <= rand_x_s;
                    end else begin
                        y_r[i] <= y_r[i] + 10'd1;
                    end
                end
                if (any_wrap_s) begin
                    recycle_cnt_r <= cnt_nxt_s;
                end
            end
        end
    end

`ifdef FLOOR_THIN_EN
    logic prev_gap_r;
    logic thin_bit_s;

    // Presence draw, forced on right after a missing floor
    always_comb begin
        thin_bit_s = prev_gap_r | lfsr_r[15] | lfsr_r[14];
    end

    // Thinning of recycled floors once enough floors have gone by
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable_r   <= 8'hFF;
            prev_gap_r <= 1'b0;
        end else if (step_s && any_wrap_s && (recycle_cnt_r >= 8'd32)) begin
            for (int i = 0; i < 8; i++) begin
                if (wrap_s[i]) begin
                    enable_r[i] <= thin_bit_s;
                end
            end
            prev_gap_r <= !thin_bit_s;
        end
    end
`else
    // Every floor is always present in the default build
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable_r <= 8'hFF;
        end else begin
            enable_r <= 8'hFF;
        end
    end
`endif

    assign floor_pos_x0 = x_r[0];
    assign floor_pos_x1 = x_r[1];
    assign floor_pos_x2 = x_r[2];
    assign floor_pos_x3 = x_r[3];
    assign floor_pos_x4 = x_r[4];
    assign floor_pos_x5 = x_r[5];
    assign floor_pos_x6 = x_r[6];
    assign floor_pos_x7 = x_r[7];
    assign floor_pos_y0 = y_r[0];
    assign floor_pos_y1 = y_r[1];
    assign floor_pos_y2 = y_r[2];
    assign floor_pos_y3 = y_r[3];
    assign floor_pos_y4 = y_r[4];
    assign floor_pos_y5 = y_r[5];
    assign floor_pos_y6 = y_r[6];
    assign floor_pos_y7 = y_r[7];
    assign enable       = enable_r;
    assign scroll       = scroll_r;
    assign recycle_cnt  = recycle_cnt_r;

endmodule

// File: tb/tb_floor_scroller.sv
// Scoreboard bench for floor_scroller: a behavioural model pushes expected outputs per drive,
// a monitor pops and compares one cycle later; scenario tasks add end-of-scenario checks.
module tb_floor_scroller;

    logic       clk = 1'b0;
    logic       clk_on = 1'b0;
    logic       rst_n = 1'b1;
    logic       clk_vga = 1'b0;
    logic       hit_ceiling = 1'b0;
    logic [8:0] time_gap = 9'd0;
    logic       slime_die = 1'b0;
    logic [9:0] fx0, fx1, fx2, fx3, fx4, fx5, fx6, fx7;
    logic [9:0] fy0, fy1, fy2, fy3, fy4, fy5, fy6, fy7;
    logic [7:0] enable;
    logic       scroll;
    logic [7:0] recycle_cnt;

    floor_scroller dut (
        .clk(clk), .rst_n(rst_n), .clk_vga(clk_vga), .hit_ceiling(hit_ceiling),
        .time_gap(time_gap), .slime_die(slime_die),
        .floor_pos_x0(fx0), .floor_pos_x1(fx1), .floor_pos_x2(fx2), .floor_pos_x3(fx3),
        .floor_pos_x4(fx4), .floor_pos_x5(fx5), .floor_pos_x6(fx6), .floor_pos_x7(fx7),
        .floor_pos_y0(fy0), .floor_pos_y1(fy1), .floor_pos_y2(fy2), .floor_pos_y3(fy3),
        .floor_pos_y4(fy4), .floor_pos_y5(fy5), .floor_pos_y6(fy6), .floor_pos_y7(fy7),
        .enable(enable), .scroll(scroll), .recycle_cnt(recycle_cnt)
    );

    always begin
        #5;
        if (clk_on) clk = ~clk;
    end

    wire [79:0] y_all = {fy7, fy6, fy5, fy4, fy3, fy2, fy1, fy0};
    wire [79:0] x_all = {fx7, fx6, fx5, fx4, fx3, fx2, fx1, fx0};

    typedef struct packed {
        logic [79:0] y;
        logic [79:0] x;
        logic [7:0]  en;
        logic        sc;
        logic [7:0]  cnt;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   pass_cnt = 0;
    int   chk_cnt = 0;
    int   fail_cnt = 0;
    int   obs_pulses = 0;

    logic [9:0]  m_y[8];
    logic [9:0]  m_x[8];
    logic [7:0]  m_en;
    logic [7:0]  m_cnt;
    logic        m_dead;
    logic        m_gap;
    logic [15:0] m_lfsr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= 16'hACE1;
        else        m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
    end

    function automatic logic phase_ok(input logic [8:0] tg);
        int t;
        t = int'(tg);
        if (t >= 1 && t < 80)    return 1'b1;
        if (t >= 80 && t < 160)  return (t % 2) == 0;
        if (t >= 160 && t < 240) return (t % 4) == 0;
        if (t >= 240 && t < 320) return (t % 8) == 0;
        return 1'b0;
    endfunction

    function automatic logic [79:0] pack_y();
        logic [79:0] v;
        for (int i = 0; i < 8; i++) v[i*10 +: 10] = m_y[i];
        return v;
    endfunction

    function automatic logic [79:0] pack_x();
        logic [79:0] v;
        for (int i = 0; i < 8; i++) v[i*10 +: 10] = m_x[i];
        return v;
    endfunction

    task automatic model_reset();
        int xt[8];
        xt = '{290, 100, 450, 200, 500, 50, 350, 250};
        for (int i = 0; i < 8; i++) begin
            m_y[i] = 10'(460 - 60 * i);
            m_x[i] = 10'(xt[i]);
        end
        m_en = 8'hFF; m_cnt = 8'd0; m_dead = 1'b0; m_gap = 1'b0;
    endtask

    // One drive cycle: apply inputs at negedge, predict the post-edge outputs
    task automatic drive(input logic tick, input logic hc, input logic [8:0] tg, input logic die);
        exp_t e;
        logic stp, any, nb;
        logic [9:0] r, rx;
        logic [7:0] wr;
        @(negedge clk);
        clk_vga = tick; hit_ceiling = hc; time_gap = tg; slime_die = die;
        stp = !m_dead && !die && tick && hc && phase_ok(tg);
        if (die) m_dead = 1'b1;
        if (stp) begin
            r  = m_lfsr[9:0];
            rx = (r < 10'd580) ? r : r - 10'd580;
            any = 1'b0; wr = 8'h00;
            for (int i = 0; i < 8; i++) begin
                if (m_y[i] == 10'd479) begin
                    m_y[i] = 10'd0; m_x[i] = rx; any = 1'b1; wr[i] = 1'b1;
                end else begin
                    m_y[i] = m_y[i] + 10'd1;
                end
            end
`ifdef FLOOR_THIN_EN
            if (any && m_cnt >= 8'd32) begin
                nb = m_gap | m_lfsr[15] | m_lfsr[14];
                for (int i = 0; i < 8; i++) if (wr[i]) m_en[i] = nb;
                m_gap = !nb;
            end
`else
            nb = 1'b1;
`endif
            if (any && m_cnt != 8'd255) m_cnt = m_cnt + 8'd1;
        end
        e.y = pack_y(); e.x = pack_x(); e.en = m_en; e.sc = stp; e.cnt = m_cnt;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 9'd0, 1'b0);
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        #1;
        if (scroll === 1'b1) obs_pulses++;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk_cnt += 5;
            if (y_all !== mon_e.y) begin
                fail_cnt++;
                if (fail_cnt <= 20) $display("FAIL sb_y: got %h want %h", y_all, mon_e.y);
            end else pass_cnt++;
            if (x_all !== mon_e.x) begin
                fail_cnt++;
                if (fail_cnt <= 20) $display("FAIL sb_x: got %h want %h", x_all, mon_e.x);
            end else pass_cnt++;
            if (enable !== mon_e.en) begin
                fail_cnt++;
                if (fail_cnt <= 20) $display("FAIL sb_enable: got %h want %h", enable, mon_e.en);
            end else pass_cnt++;
            if (scroll !== mon_e.sc) begin
                fail_cnt++;
                if (fail_cnt <= 20) $display("FAIL sb_scroll: got %b want %b", scroll, mon_e.sc);
            end else pass_cnt++;
            if (recycle_cnt !== mon_e.cnt) begin
                fail_cnt++;
                if (fail_cnt <= 20) $display("FAIL sb_recycle_cnt: got %0d want %0d", recycle_cnt, mon_e.cnt);
            end else pass_cnt++;
        end
    end

    // Reset layout check, shared by the power-on and the post-freeze reset
    task automatic check_layout(input string tag);
        chk_cnt += 5;
        if (y_all !== pack_y()) begin fail_cnt++; $display("FAIL %s_y: got %h want %h", tag, y_all, pack_y()); end else pass_cnt++;
        if (x_all !== pack_x()) begin fail_cnt++; $display("FAIL %s_x: got %h want %h", tag, x_all, pack_x()); end else pass_cnt++;
        if (enable !== 8'hFF) begin fail_cnt++; $display("FAIL %s_enable: got %h want ff", tag, enable); end else pass_cnt++;
        if (scroll !== 1'b0) begin fail_cnt++; $display("FAIL %s_scroll: got %b want 0", tag, scroll); end else pass_cnt++;
        if (recycle_cnt !== 8'd0) begin fail_cnt++; $display("FAIL %s_cnt: got %0d want 0", tag, recycle_cnt); end else pass_cnt++;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        model_reset();
        #2;
        check_layout("reset");
        clk_on = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_jump_profile();
        int p0;
        p0 = obs_pulses;
        for (int tg = 1; tg <= 320; tg++) drive(1'b1, 1'b1, 9'(tg), 1'b0);
        idle(2);
        chk_cnt += 3;
        if (obs_pulses - p0 != 149) begin fail_cnt++; $display("FAIL jump_pulses: got %0d want 149", obs_pulses - p0); end else pass_cnt++;
        if (fy0 !== 10'd129) begin fail_cnt++; $display("FAIL jump_y0: got %0d want 129", fy0); end else pass_cnt++;
        if (recycle_cnt !== 8'd3) begin fail_cnt++; $display("FAIL jump_cnt: got %0d want 3", recycle_cnt); end else pass_cnt++;
    endtask

    task automatic test_idle_guard();
        int p0;
        logic [8:0] tgs[6];
        tgs = '{9'd0, 9'd5, 9'd100, 9'd200, 9'd320, 9'd511};
        p0 = obs_pulses;
        for (int k = 0; k < 6; k++) drive(1'b1, 1'b0, tgs[k], 1'b0);
        for (int k = 0; k < 5; k++) drive(1'b0, 1'b1, 9'd1, 1'b0);
        tgs = '{9'd0, 9'd81, 9'd162, 9'd244, 9'd320, 9'd400};
        for (int k = 0; k < 6; k++) drive(1'b1, 1'b1, tgs[k], 1'b0);
        idle(2);
        chk_cnt += 2;
        if (obs_pulses != p0) begin fail_cnt++; $display("FAIL idle_pulses: got %0d want 0", obs_pulses - p0); end else pass_cnt++;
        if (fy0 !== 10'd129) begin fail_cnt++; $display("FAIL idle_y0: got %0d want 129", fy0); end else pass_cnt++;
    endtask

    task automatic test_freeze();
        int p0;
        p0 = obs_pulses;
        for (int k = 0; k < 10; k++) drive(1'b1, 1'b1, 9'd10, 1'b0);
        drive(1'b1, 1'b1, 9'd10, 1'b1);
        for (int k = 0; k < 20; k++) drive(1'b1, 1'b1, 9'd10, 1'b0);
        idle(2);
        chk_cnt += 2;
        if (obs_pulses - p0 != 10) begin fail_cnt++; $display("FAIL freeze_pulses: got %0d want 10", obs_pulses - p0); end else pass_cnt++;
        if (fy0 !== 10'd139) begin fail_cnt++; $display("FAIL freeze_y0: got %0d want 139", fy0); end else pass_cnt++;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_layout("rereset");
        @(negedge clk);
        rst_n = 1'b1;
        p0 = obs_pulses;
        for (int k = 0; k < 3; k++) drive(1'b1, 1'b1, 9'd40, 1'b0);
        idle(2);
        chk_cnt += 1;
        if (obs_pulses - p0 != 3) begin fail_cnt++; $display("FAIL rerun_pulses: got %0d want 3", obs_pulses - p0); end else pass_cnt++;
    endtask

    task automatic test_recycle_range();
        logic [9:0] ys[8];
        logic [9:0] xs[8];
        for (int k = 0; k < 15500; k++) drive(1'b1, 1'b1, 9'($urandom_range(79, 1)), 1'b0);
        idle(2);
        ys = '{fy0, fy1, fy2, fy3, fy4, fy5, fy6, fy7};
        xs = '{fx0, fx1, fx2, fx3, fx4, fx5, fx6, fx7};
        chk_cnt += 1;
        if (recycle_cnt !== 8'd255) begin fail_cnt++; $display("FAIL sat_cnt: got %0d want 255", recycle_cnt); end else pass_cnt++;
        for (int i = 1; i < 8; i++) begin
            chk_cnt++;
            if ((int'(ys[i]) + 60 * i) % 480 != int'(ys[0])) begin
                fail_cnt++; $display("FAIL pitch_y%0d: got %0d want %0d", i, ys[i], (int'(ys[0]) + 480 - 60 * i) % 480);
            end else pass_cnt++;
        end
        for (int i = 0; i < 8; i++) begin
            chk_cnt++;
            if (xs[i] > 10'd579) begin fail_cnt++; $display("FAIL x_range%0d: got %0d want <=579", i, xs[i]); end else pass_cnt++;
        end
    endtask

    task automatic test_thin();
        chk_cnt++;
`ifdef FLOOR_THIN_EN
        if (enable === 8'hFF) begin fail_cnt++; $display("FAIL thin_enable: got %h want some bit clear", enable); end else pass_cnt++;
`else
        if (enable !== 8'hFF) begin fail_cnt++; $display("FAIL thin_enable: got %h want ff", enable); end else pass_cnt++;
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_jump_profile();
        test_idle_guard();
        test_freeze();
        test_recycle_range();
        test_thin();
        chk_cnt++;
        if (sb.size() != 0) begin fail_cnt++; $display("FAIL sb_drain: got %0d want 0", sb.size()); end else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
